poly_instr_ctrl: RTL

Top-level instruction sequencer for the polynomial evaluation accelerator. Pops 16-bit instruction words from the instruction FIFO, decodes opcode and arguments, and dispatches exactly one instruction FSM at a time (STP, EVP, EVB, RST) with a one-cycle start pulse. Waits for that FSM's done, then fetches the next word. It writes its own status word only for illegal opcodes and watchdog timeouts; the instruction FSMs own result and status output in every other case.

---
 rtl/poly_instr_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/poly_instr_ctrl.sv
// Instruction sequencer for the polynomial evaluation accelerator: fetches and decodes
// instruction words, dispatches one instruction FSM at a time and reports its own errors.
module poly_instr_ctrl #(
  parameter int word_size      = 16,
  parameter int timeout_cycles = 4096,
  parameter int cnt_width      = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_empty,
  input  logic [word_size-1:0] instr_dout,
  output logic                 instr_rd_en,
  input  logic                 status_full,
  output logic                 status_wr_en,
  output logic [31:0]          status_din,
  output logic                 start_stp,
  output logic                 start_evp,
  output logic                 start_evb,
  output logic                 start_rst,
  input  logic                 done_stp,
  input  logic                 done_evp,
  input  logic                 done_evb,
  input  logic                 done_rst,
  output logic [2:0]           A,
  output logic [4:0]           N,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_DISPATCH = 3'd3,
    S_WAIT     = 3'd4,
    S_ERR      = 3'd5
  } state_t;

  localparam logic [cnt_width-1:0] WD_LAST = cnt_width'(timeout_cycles - 1);
  localparam logic [cnt_width-1:0] WD_MAX  = {cnt_width{1'b1}};
  localparam logic [cnt_width-1:0] WD_ONE  = {{(cnt_width-1){1'b0}}, 1'b1};

  state_t               state_r, state_s;
  logic [1:0]           op_r, op_s;
  logic [2:0]           a_r, a_s;
  logic [4:0]           n_r, n_s;
  logic [cnt_width-1:0] wd_r, wd_s;
  logic [3:0]           start_r, start_s;
  logic                 rd_en_r, rd_en_s;
  logic                 wr_en_r, wr_en_s;
  logic [31:0]          status_r, status_s;
  logic                 busy_r, busy_s;
  logic                 tmo_r, tmo_s;
  logic [3:0]           done_s;

  assign done_s = {done_rst, done_evb, done_evp, done_stp};

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_s  = state_r;
    op_s     = op_r;
    a_s      = a_r;
    n_s      = n_r;
    wd_s     = wd_r;
    start_s  = 4'b0000;
    rd_en_s  = 1'b0;
    wr_en_s  = 1'b0;
    status_s = status_r;
    tmo_s    = tmo_r;
    case (state_r)
      S_IDLE: begin
        if (!instr_empty) begin
          state_s = S_FETCH;
          rd_en_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: state_s = S_DECODE;
      S_DECODE: begin
        op_s = instr_dout[14:13];
        a_s  = instr_dout[12:10];
        n_s  = instr_dout[9:5];
        if (instr_dout[15]) begin
          status_s = 32'd3;
          state_s  = S_ERR;
        end else begin
          state_s = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        start_s = 4'b0001 << op_r;
        wd_s    = {cnt_width{1'b0}};
        state_s = S_WAIT;
      end
      S_WAIT: begin
        // A matching done takes priority over an expiring watchdog in the same cycle
        if (done_s[op_r]) begin
          state_s = S_IDLE;
        end else if (wd_r == WD_LAST) begin
          tmo_s    = 1'b1;
          status_s = 32'd4;
          state_s  = S_ERR;
        end else if (wd_r != WD_MAX) begin
          wd_s = wd_r + WD_ONE;
        end else begin
          wd_s = wd_r;
        end
      end
      S_ERR: begin
        if (!status_full) begin
          wr_en_s = 1'b1;
          state_s = S_IDLE;
        end else begin
          state_s = S_ERR;
        end
      end
      default: state_s = S_IDLE;
    endcase
    busy_s = (state_s != S_IDLE);
  end

  // State and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      op_r     <= 2'd0;
      a_r      <= 3'd0;
      n_r      <= 5'd0;
      wd_r     <= {cnt_width{1'b0}};
      start_r  <= 4'b0000;
      rd_en_r  <= 1'b0;
      wr_en_r  <= 1'b0;
      status_r <= 32'd0;
      busy_r   <= 1'b0;
      tmo_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      op_r     <= op_s;
      a_r      <= a_s;
      n_r      <= n_s;
      wd_r     <= wd_s;
      start_r  <= start_s;
      rd_en_r  <= rd_en_s;
      wr_en_r  <= wr_en_s;
      status_r <= status_s;
      busy_r   <= busy_s;
      tmo_r    <= tmo_s;
    end
  end

  assign instr_rd_en  = rd_en_r;
  assign status_wr_en = wr_en_r;
  assign status_din   = status_r;
  assign start_stp    = start_r[0];
  assign start_evp    = start_r[1];
  assign start_evb    = start_r[2];
  assign start_rst    = start_r[3];
  assign A            = a_r;
  assign N            = n_r;
  assign busy         = busy_r;
  assign timeout_err  = tmo_r;

endmodule
